ic_mem_responder: RTL

IC_MEM_RESPONDER -- requirements
Module: ic_mem_responder

---
 rtl/ic_mem_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ic_mem_responder.sv
// ic_mem_responder: single-outstanding memory target that fronts an SRAM macro.
// Accepts one request at a time from the initiator, decodes it, optionally
// inserts wait states, issues a single SRAM cycle, and holds the response
// until the initiator acknowledges it.
//
// Ports
//   g_clk, g_resetn           clock, synchronous active-low reset
//   mem_req/wen/strb/wdata/addr  initiator request
//   mem_gnt                   request accepted this cycle (combinational in IDLE)
//   mem_recv/error/rdata      response, held until mem_ack
//   mem_ack                   initiator accepts the response
//   sram_cen/wen/strb/addr/wdata  SRAM command, valid only while sram_cen=1
//   sram_rdata                SRAM read data, valid the cycle after sram_cen
module ic_mem_responder #(
  parameter int MEM_WORDS   = 16384,
  parameter int WAIT_CYCLES = 0,
  parameter int READ_ONLY   = 0
) (
  input  logic                         g_clk,
  input  logic                         g_resetn,
  input  logic                         mem_req,
  input  logic                         mem_wen,
  input  logic [3:0]                   mem_strb,
  input  logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_addr,
  output logic                         mem_gnt,
  output logic                         mem_recv,
  output logic                         mem_error,
  output logic [31:0]                  mem_rdata,
  input  logic                         mem_ack,
  output logic                         sram_cen,
  output logic                         sram_wen,
  output logic [3:0]                   sram_strb,
  output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
  output logic [31:0]                  sram_wdata,
  input  logic [31:0]                  sram_rdata
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   resp_q;
  logic          err_q;

  logic          wen_q;
  logic [3:0]    strb_q;
  logic [31:0]   wdata_q;
  logic [AW-1:0] idx_q;

  logic [31:0]   word_idx;
  logic          dec_err;

  assign word_idx = {2'b00, mem_addr[31:2]};
  // Full 30-bit index is range-checked so aliasing above MEM_WORDS is an error.
  assign dec_err  = (mem_addr[1:0] != 2'b00) ||
                    (word_idx >= 32'(MEM_WORDS)) ||
                    ((READ_ONLY != 0) && mem_wen);

  assign mem_gnt  = (state == S_IDLE) && mem_req;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_gnt) begin
            if (dec_err) begin
              // Errors bypass the SRAM entirely and respond next cycle.
              err_q  <= 1'b1;
              resp_q <= '0;
              state  <= S_RESP;
            end else begin
              err_q    <= 1'b0;
              wait_cnt <= CW'(WAIT_CYCLES);
              state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt <= CW'(1)) begin
            wait_cnt <= '0;
            state    <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        S_ACCESS:  state <= S_CAPTURE;
        S_CAPTURE: begin
          resp_q <= wen_q ? 32'd0 : sram_rdata;
          err_q  <= 1'b0;
          state  <= S_RESP;
        end
        S_RESP:    if (mem_ack) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Request fields only matter after a grant, so they carry no reset.
  always_ff @(posedge g_clk) begin
    if (mem_gnt) begin
      wen_q   <= mem_wen;
      strb_q  <= mem_strb;
      wdata_q <= mem_wdata;
      idx_q   <= word_idx[AW-1:0];
    end
  end

  assign mem_recv   = (state == S_RESP);
  assign mem_rdata  = mem_recv ? resp_q : 32'd0;
  assign mem_error  = mem_recv & err_q;

  assign sram_cen   = (state == S_ACCESS);
  assign sram_wen   = wen_q;
  assign sram_strb  = strb_q;
  assign sram_addr  = idx_q;
  assign sram_wdata = wdata_q;

endmodule
